// File: rtl/keypad_pkg.sv
// Shared types, key codes and helper functions for the 4x4 keypad encoder.
package keypad_pkg;

  // Scanner / debouncer states.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Codes for the non-digit keys; digits use their own value.
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Column drive after reset: column 0 active (low).
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Map (row index, column index) to the 4-bit key code.
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = KEY_A;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = KEY_B;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'd0;
      4'hE:    code = KEY_HASH;
      4'hF:    code = KEY_D;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Index of the lowest-numbered active-low row (0 when none is low).
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rs);
    logic [1:0] idx;
    casez (rs)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Index of the single low bit in a column drive pattern.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Next column in the rotation 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] next_col(input logic [3:0] col);
    logic [3:0] nxt;
    case (col)
      4'b1110: nxt = 4'b1101;
      4'b1101: nxt = 4'b1011;
      4'b1011: nxt = 4'b0111;
      4'b0111: nxt = 4'b1110;
      default: nxt = COL_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module keypad_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_d, meta_q;
  logic [3:0] sync_d, sync_q;

  // Next-state for the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages; idle (all rows released) after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner with press/release debounce and 4-bit key encoding.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       x3,
  output logic       x2,
  output logic       x1,
  output logic       x0,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SD_W-1:0] DWELL_LAST = SD_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);

  logic [3:0] rs;

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (rs)
  );

  state_e          state_d, state_q;
  logic [3:0]      col_d, col_q;
  logic [SD_W-1:0] dwell_d, dwell_q;
  logic [DB_W-1:0] db_d, db_q;
  logic [1:0]      row_idx_d, row_idx_q;
  logic [1:0]      col_idx_d, col_idx_q;
  logic [3:0]      code_d, code_q;
  logic            key_valid_d, key_valid_q;
  logic            key_held_d, key_held_q;
  logic            row_low_s;

  // Next-state logic for scanning, press debounce, hold and release debounce.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    code_d      = code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    row_low_s   = ~rs[row_idx_q];

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rs == 4'b1111) begin
            col_d = next_col(col_q);
          end else begin
            // Freeze the column and remember which key to watch.
            row_idx_d = lowest_low_row(rs);
            col_idx_d = col_index(col_q);
            db_d      = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + SD_W'(1);
        end
      end

      DEBOUNCE: begin
        if (row_low_s) begin
          if (db_q == DB_LAST) begin
            code_d      = keymap(row_idx_q, col_idx_q);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            db_d        = '0;
            state_d     = HELD;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end else begin
          // Bounce: abandon the press and resume dwelling on the same column.
          db_d    = '0;
          dwell_d = '0;
          state_d = SCAN;
        end
      end

      HELD: begin
        if (!row_low_s) begin
          db_d    = '0;
          state_d = RELEASE;
        end else begin
          state_d = HELD;
        end
      end

      RELEASE: begin
        if (!row_low_s) begin
          if (db_q == DB_LAST) begin
            key_held_d = 1'b0;
            col_d      = next_col(col_q);
            dwell_d    = '0;
            db_d       = '0;
            state_d    = SCAN;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end else begin
          db_d = '0;
        end
      end

      default: begin
        state_d    = SCAN;
        col_d      = COL_RESET;
        dwell_d    = '0;
        db_d       = '0;
        key_held_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= COL_RESET;
      dwell_q     <= '0;
      db_q        <= '0;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      code_q      <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      code_q      <= code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign x3        = code_q[3];
  assign x2        = code_q[2];
  assign x1        = code_q[1];
  assign x0        = code_q[0];
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Scans a 4x4 matrix keypad, debounces key presses and releases, and encodes the pressed key as a 4-bit code on x3..x0. This is the input-side counterpart of the seven-segment decoder: it produces the 4-bit code the decoder consumes. Digits 0–9 map to codes 0–9; the remaining six keys map to codes 10–15, which the decoder renders as its default pattern.

## Interface
- SCAN_DIV, default 1000: clock cycles each column is driven before its rows are sampled (≥2).
- DEBOUNCE_CNT, default 250000: consecutive stable cycles required to accept a press or a release (≥1).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- row  in  4  keypad rows, active-low (pulled up externally), asynchronous to clk.
- col  out  4  keypad column drive, active-low, exactly one bit low at all times.
- x3, x2, x1, x0  out  1 each  encoded key, x3 = MSB; holds the last accepted key.
- key_valid  out  1  single-cycle pulse when a new key is accepted.
- key_held  out  1  high from acceptance until the release is accepted.

## Operation
- row passes through a 2-flop synchronizer; all logic uses the synchronized value rs.
- Key map (row r, col c), with r0 = row[0] and c0 = col[0]:
  - r0: 1 2 3 A(10)
  - r1: 4 5 6 B(11)
  - r2: 7 8 9 C(12)
  - r3: *(14) 0 #(15) D(13)
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - Dwell counter counts 0..SCAN_DIV-1. rs is sampled only when the count is SCAN_DIV-1.
  - If no row is low at the sample, advance the column (1110→1101→1011→0111→1110) and clear the counter.
  - If any row is low, latch the column index and the lowest-index low row, freeze col, and go to DEBOUNCE.
- DEBOUNCE:
  - Counter increments each cycle the latched row bit is low.
  - If that bit goes high, return to SCAN with col unchanged, counter cleared, and no output.
  - When the counter reaches DEBOUNCE_CNT-1: load {x3..x0} from the key map, pulse key_valid, go to HELD.
- HELD: key_held=1 and col stays frozen. Other rows going low are ignored. When the latched row goes high, go to RELEASE.
- RELEASE:
  - Counter counts consecutive cycles with the latched row high; the row going low clears it.
  - When it reaches DEBOUNCE_CNT-1: key_held=0, advance col, go to SCAN.
- Reset, including mid-operation: state=SCAN, col=1110, {x3..x0}=0000, key_valid=0, key_held=0, all counters 0, synchronizer flops = 1111. A press in progress is discarded.
- Codes never change except on a key_valid cycle.

## Timing
- All outputs are registered; no combinational path from row to any output.
- Press latency: a row edge reaches rs after 2 cycles. Then wait up to SCAN_DIV cycles (×4 columns worst case) for the sample, plus DEBOUNCE_CNT cycles to key_valid. The code appears in the same cycle as key_valid.
- key_valid is high for exactly 1 cycle per accepted press, and never twice without an intervening accepted release.
- key_held rises in the same cycle as key_valid and falls DEBOUNCE_CNT cycles after the release is stable in rs.
- col changes only in SCAN at dwell end or on RELEASE completion, so each column holds for at least SCAN_DIV cycles.

## Structure
- Package keypad_pkg holds:
  - state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - key-code constants KEY_A..KEY_HASH;
  - keymap function (row index, col index) → 4-bit code;
  - column reset constant 4'b1110.
- Sub-module keypad_sync: a 4-bit 2-flop synchronizer, reset to 1111.
- The debounce counter is sized $clog2(DEBOUNCE_CNT) and is shared between DEBOUNCE and RELEASE.

## Test plan
Bench uses SCAN_DIV=4 and DEBOUNCE_CNT=8. The keypad model shorts row r to col c while a key is pressed.
- Reset: assert reset for 2 cycles → col=1110, code=0000, key_valid=0, key_held=0. Col then rotates every 4 cycles.
- Press "5" (r1, c1) cleanly for 40 cycles → exactly one key_valid with code 0101. key_held=1 until 8 cycles after the release reaches rs.
- Bounce: toggle "9" (r2, c2) low 3 cycles / high 1 cycle, three times, then hold → a single key_valid with code 1001, only after 8 stable cycles. No pulse during the bounce.
- Glitch: "D" (r3, c3) low for 5 cycles only → no key_valid, code keeps its prior value, scanning resumes.
- Simultaneous: "1" and "7" (both c0) pressed together → code 0001 (lowest row wins). Pressing "4" while "1" is held → no new pulse.
- Reset mid-HELD with "#" (code 1111) held → outputs return to reset values in 1 cycle. After reset, "#" is re-detected and accepted again (key_valid, code 1111).
